// File: rtl/cache_snoop_bus_if.sv
// Snoop bus encodings and the cache-side handshake bundle.
// Caches use the master modport; the interconnect uses slave.
package cache_pkg;
  localparam logic [2:0] SDREQ_RD    = 3'd0;
  localparam logic [2:0] SDREQ_RFO   = 3'd1;
  localparam logic [2:0] SDREQ_INV   = 3'd2;
  localparam logic [2:0] SDREQ_WB    = 3'd3;
  localparam logic [1:0] SUREQ_RD    = 2'd0;
  localparam logic [1:0] SUREQ_RFO   = 2'd1;
  localparam logic [1:0] SUREQ_INV   = 2'd2;
  localparam logic [1:0] SDRSP_OKAY  = 2'd0;
  localparam logic [1:0] SDRSP_INV   = 2'd1;
  localparam logic [1:0] SDRSP_ERROR = 2'd2;
  localparam logic [2:0] SURSP_OKAY  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;
  localparam logic [2:0] SURSP_ERROR = 3'd3;
endpackage

interface cache_snoop_bus_if #(
  parameter int NUM_CACHE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CACHE-1:0]            sdreq_valid;
  logic [NUM_CACHE-1:0]            sdreq_ready;
  logic [3*NUM_CACHE-1:0]          sdreq_op;
  logic [ADDR_WIDTH*NUM_CACHE-1:0] sdreq_addr;
  logic [NUM_CACHE-1:0]            sureq_valid;
  logic [NUM_CACHE-1:0]            sureq_ready;
  logic [1:0]                      sureq_op;
  logic [ADDR_WIDTH-1:0]           sureq_addr;
  logic [NUM_CACHE-1:0]            sdrsp_valid;
  logic [NUM_CACHE-1:0]            sdrsp_ready;
  logic [2*NUM_CACHE-1:0]          sdrsp_rsp;
  logic [NUM_CACHE-1:0]            sdrsp_hit;
  logic [DATA_WIDTH*NUM_CACHE-1:0] sdrsp_data;
  logic [NUM_CACHE-1:0]            sursp_valid;
  logic [NUM_CACHE-1:0]            sursp_ready;
  logic [2:0]                      sursp_rsp;
  logic [DATA_WIDTH-1:0]           sursp_data;

  modport master (
    output sdreq_valid, sdreq_op, sdreq_addr,
    input  sdreq_ready,
    input  sureq_valid, sureq_op, sureq_addr,
    output sureq_ready,
    output sdrsp_valid, sdrsp_rsp, sdrsp_hit, sdrsp_data,
    input  sdrsp_ready,
    input  sursp_valid, sursp_rsp, sursp_data,
    output sursp_ready
  );

  modport slave (
    input  sdreq_valid, sdreq_op, sdreq_addr,
    output sdreq_ready,
    output sureq_valid, sureq_op, sureq_addr,
    input  sureq_ready,
    input  sdrsp_valid, sdrsp_rsp, sdrsp_hit, sdrsp_data,
    output sdrsp_ready,
    output sursp_valid, sursp_rsp, sursp_data,
    input  sursp_ready
  );
endinterface

// File: rtl/cache_snoop_bus.sv
// Round-robin MESI snoop interconnect between NUM_CACHE caches.
// Define SNOOP_TIMEOUT_EN to bound the snoop/collect phases.
module cache_snoop_bus
  import cache_pkg::*;
#(
  parameter int NUM_CACHE      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_snoop_bus_if.slave bus
);

  localparam int PW = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;

  typedef enum logic [1:0] {
    IDLE, SNOOP, COLLECT, RESP
  } state_t;

  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] req, req_n;
  logic [2:0] op, op_n;
  logic [NUM_CACHE-1:0] snp, snp_n;
  logic [NUM_CACHE-1:0] pend, pend_n;
  logic [NUM_CACHE-1:0] acc;
  logic err, err_n;
  logic hit, hit_n;
  logic [PW-1:0] hidx, hidx_n;
  logic [DATA_WIDTH-1:0] hdat, hdat_n;
  logic [DATA_WIDTH-1:0] dat, dat_n;
  logic [2:0] rsp, rsp_n;
  logic [1:0] sop, sop_n;
  logic [ADDR_WIDTH-1:0] sadr, sadr_n;
  logic gv;
  int gi;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  if (NUM_CACHE < 2 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("cache_snoop_bus: bad parameters");
  end

  assign bus.sureq_valid = snp;
  assign bus.sureq_op    = sop;
  assign bus.sureq_addr  = sadr;
  assign bus.sdrsp_ready = pend;
  assign bus.sursp_rsp   = rsp;
  assign bus.sursp_data  = dat;

  // First requester after the last grant, wrapping.
  always_comb begin
    gv = 1'b0;
    gi = 0;
    for (int k = 1; k <= NUM_CACHE; k++) begin
      if (rst_n && !gv &&
          bus.sdreq_valid[(int'(ptr) + k) % NUM_CACHE]) begin
        gv = 1'b1;
        gi = (int'(ptr) + k) % NUM_CACHE;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    req_n   = req;
    op_n    = op;
    snp_n   = snp;
    pend_n  = pend;
    err_n   = err;
    hit_n   = hit;
    hidx_n  = hidx;
    hdat_n  = hdat;
    dat_n   = dat;
    rsp_n   = rsp;
    sop_n   = sop;
    sadr_n  = sadr;
    bus.sdreq_ready = '0;
    bus.sursp_valid = '0;
    acc = bus.sdrsp_valid & pend;

    unique case (state)
      IDLE: begin
        if (gv) begin
          bus.sdreq_ready[gi] = 1'b1;
          ptr_n  = PW'(gi);
          req_n  = PW'(gi);
          op_n   = bus.sdreq_op[gi*3 +: 3];
          err_n  = 1'b0;
          hit_n  = 1'b0;
          hidx_n = '0;
          hdat_n = '0;
          dat_n  = '0;
          unique case (1'b1)
            (op_n == SDREQ_WB): begin
              state_n = RESP;
              rsp_n   = SURSP_OKAY;
            end
            op_n[2]: begin
              state_n = RESP;
              rsp_n   = SURSP_ERROR;
            end
            default: begin
              state_n = SNOOP;
              snp_n   = '1;
              snp_n[gi] = 1'b0;
              sop_n   = (op_n == SDREQ_RFO) ? SUREQ_RFO :
                        (op_n == SDREQ_INV) ? SUREQ_INV :
                        SUREQ_RD;
              sadr_n  = bus.sdreq_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            end
          endcase
        end
      end
      SNOOP: begin
        snp_n  = snp & ~bus.sureq_ready;
        pend_n = (pend & ~acc) | (snp & bus.sureq_ready);
        if (snp_n == '0) state_n = COLLECT;
      end
      COLLECT: begin
        pend_n = pend & ~acc;
        if (pend == '0) begin
          state_n = RESP;
          dat_n   = '0;
          if (err)                    rsp_n = SURSP_ERROR;
          else if (op == SDREQ_INV)   rsp_n = SURSP_OKAY;
          else if (hit) begin
            rsp_n = SURSP_SNOOP;
            dat_n = hdat;
          end
          else                        rsp_n = SURSP_FETCH;
        end
      end
      RESP: begin
        bus.sursp_valid[req] = 1'b1;
        if (bus.sursp_ready[req]) begin
          state_n = IDLE;
          rsp_n   = SURSP_OKAY;
          dat_n   = '0;
        end
      end
    endcase

    // Responses may arrive over several cycles; keep the lowest hitter.
    for (int i = 0; i < NUM_CACHE; i++) begin
      if (acc[i]) begin
        if (bus.sdrsp_rsp[2*i +: 2] == SDRSP_ERROR) err_n = 1'b1;
        if (bus.sdrsp_hit[i] && (!hit_n || PW'(i) < hidx_n)) begin
          hit_n  = 1'b1;
          hidx_n = PW'(i);
          hdat_n = bus.sdrsp_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

`ifdef SNOOP_TIMEOUT_EN
    cnt_n = '0;
    if (state == SNOOP || state == COLLECT) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        cnt_n   = '0;
        snp_n   = '0;
        pend_n  = '0;
        state_n = RESP;
        rsp_n   = SURSP_ERROR;
        dat_n   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= PW'(NUM_CACHE - 1);
      req   <= '0;
      op    <= '0;
      snp   <= '0;
      pend  <= '0;
      err   <= 1'b0;
      hit   <= 1'b0;
      hidx  <= '0;
      hdat  <= '0;
      dat   <= '0;
      rsp   <= '0;
      sop   <= '0;
      sadr  <= '0;
`ifdef SNOOP_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      req   <= req_n;
      op    <= op_n;
      snp   <= snp_n;
      pend  <= pend_n;
      err   <= err_n;
      hit   <= hit_n;
      hidx  <= hidx_n;
      hdat  <= hdat_n;
      dat   <= dat_n;
      rsp   <= rsp_n;
      sop   <= sop_n;
      sadr  <= sadr_n;
`ifdef SNOOP_TIMEOUT_EN
      cnt   <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_cache_snoop_bus.sv
// Scoreboard bench for cache_snoop_bus with modelled caches.
// Responders answer one cycle after their snoop handshake.
module tb_cache_snoop_bus;
  import cache_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_snoop_bus_if #(
    .NUM_CACHE(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) bif ();

  cache_snoop_bus #(
    .NUM_CACHE(N), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    int          idx;
    logic [2:0]  rsp;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   gnt_q[$];

  int passed = 0;
  int total  = 0;

  int          want[N];
  int          done[N];
  int          stall[N];
  int          stall_seen[N];
  logic [2:0]  op_cfg[N];
  logic [31:0] addr_cfg[N];
  logic [1:0]  rsp_cfg[N];
  logic        hit_cfg[N];
  logic [31:0] dat_cfg[N];
  logic        silent[N];

  logic [N-1:0] snooped;
  logic [N-1:0] s_sdreq, s_sureq, s_sdrsp, s_sursp;
  logic [1:0]   last_sop;
  logic [31:0]  last_saddr;
  logic         prev_rv;
  int self_snoop, cur_req, ncyc, acc_at, rsp_at;

  task automatic cyc();
    @(negedge clk);
    ncyc++;
    s_sdreq = bif.sdreq_valid & bif.sdreq_ready;
    s_sureq = bif.sureq_valid & bif.sureq_ready;
    s_sdrsp = bif.sdrsp_valid & bif.sdrsp_ready;
    s_sursp = bif.sursp_valid & bif.sursp_ready;
    snooped |= bif.sureq_valid;
    if (bif.sureq_valid != '0) begin
      last_sop   = bif.sureq_op;
      last_saddr = bif.sureq_addr;
    end
    if (bif.sureq_valid[cur_req]) self_snoop++;
    if (bif.sursp_valid != '0 && !prev_rv) rsp_at = ncyc;
    prev_rv = |bif.sursp_valid;
    for (int i = 0; i < N; i++) begin
      if (s_sdreq[i]) begin
        gnt_q.push_back(i);
        cur_req = i;
        acc_at  = ncyc;
      end
      if (s_sursp[i])
        obs_q.push_back('{i, bif.sursp_rsp, bif.sursp_data});
      if (bif.sureq_valid[i] && !bif.sureq_ready[i] && stall[i] > 0) begin
        stall_seen[i]++;
        stall[i]--;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_sdreq[i]) done[i]++;
      bif.sdreq_valid[i]         = done[i] < want[i];
      bif.sdreq_op[3*i +: 3]     = op_cfg[i];
      bif.sdreq_addr[32*i +: 32] = addr_cfg[i];
      if (s_sdrsp[i]) bif.sdrsp_valid[i] = 1'b0;
      if (s_sureq[i] && !silent[i]) begin
        bif.sdrsp_valid[i]         = 1'b1;
        bif.sdrsp_rsp[2*i +: 2]    = rsp_cfg[i];
        bif.sdrsp_hit[i]           = hit_cfg[i];
        bif.sdrsp_data[32*i +: 32] = dat_cfg[i];
      end
      bif.sureq_ready[i] = (stall[i] == 0);
    end
    bif.sursp_ready = '1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      op_cfg[i]  = SDREQ_RD;
      addr_cfg[i] = 32'h0;
      rsp_cfg[i] = SDRSP_OKAY;
      hit_cfg[i] = 1'b0;
      dat_cfg[i] = 32'h0;
      silent[i]  = 1'b0;
      stall[i]   = 0;
      stall_seen[i] = 0;
    end
    snooped    = '0;
    self_snoop = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++;
    if ({bif.sdreq_ready, bif.sureq_valid, bif.sdrsp_ready,
         bif.sursp_valid} !== '0)
      $display("FAIL reset_handshake: got %0h required 0",
               {bif.sdreq_ready, bif.sureq_valid,
                bif.sdrsp_ready, bif.sursp_valid});
    else passed++;
    total++;
    if ({bif.sureq_op, bif.sureq_addr, bif.sursp_rsp,
         bif.sursp_data} !== '0)
      $display("FAIL reset_fields: got %0h required 0",
               {bif.sureq_op, bif.sureq_addr,
                bif.sursp_rsp, bif.sursp_data});
    else passed++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_read_nosharer();
    txn_t e, o;
    clear_cfg();
    addr_cfg[0] = 32'h100;
    want[0]++;
    exp_q.push_back('{0, SURSP_FETCH, 32'h0});
    for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL rd_nosharer: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL rd_nosharer: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
    total++;
    if (snooped !== 4'b1110)
      $display("FAIL rd_targets: got %b required 1110", snooped);
    else passed++;
    total++;
    if (last_sop !== SUREQ_RD || last_saddr !== 32'h100)
      $display("FAIL rd_sureq: got %0d/%h required %0d/100",
               last_sop, last_saddr, SUREQ_RD);
    else passed++;
    total++;
    if (rsp_at - acc_at - 1 !== 3)
      $display("FAIL rd_latency: got %0d required 3",
               rsp_at - acc_at - 1);
    else passed++;
  endtask

  task automatic test_sharer();
    txn_t e, o;
    clear_cfg();
    hit_cfg[3] = 1'b1;
    dat_cfg[3] = 32'hDEAD_BEEF;
    hit_cfg[2] = 1'b1;
    dat_cfg[2] = 32'h1234;
    stall[2]   = 2;
    op_cfg[1]  = SDREQ_RFO;
    addr_cfg[1] = 32'h2040;
    want[1]++;
    exp_q.push_back('{1, SURSP_SNOOP, 32'h1234});
    for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL sharer: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL sharer: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
    total++;
    if (last_sop !== SUREQ_RFO || snooped !== 4'b1101)
      $display("FAIL sharer_sureq: got %0d/%b required %0d/1101",
               last_sop, snooped, SUREQ_RFO);
    else passed++;
  endtask

  task automatic test_round_robin();
    txn_t e, o;
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    clear_cfg();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    gnt_q.delete();
    want[0] += 2;
    for (int i = 1; i < N; i++) want[i]++;
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{exp_g[k], SURSP_FETCH, 32'h0});
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL rr_resp: no response, required idx %0d", e.idx);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL rr_resp: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= gnt_q.size())
        $display("FAIL rr_grant%0d: got none required %0d", k, exp_g[k]);
      else if (gnt_q[k] !== exp_g[k])
        $display("FAIL rr_grant%0d: got %0d required %0d",
                 k, gnt_q[k], exp_g[k]);
      else passed++;
    end
    total++;
    if (self_snoop !== 0)
      $display("FAIL rr_self_snoop: got %0d required 0", self_snoop);
    else passed++;
  endtask

  task automatic test_wb_badop();
    txn_t e, o;
    clear_cfg();
    op_cfg[2] = SDREQ_WB;
    want[2]++;
    exp_q.push_back('{2, SURSP_OKAY, 32'h0});
    for (int k = 0; k < 30 && obs_q.size() < 1; k++) cyc();
    total++;
    if (snooped !== '0)
      $display("FAIL wb_nosnoop: got %b required 0000", snooped);
    else passed++;
    op_cfg[0] = 3'b110;
    want[0]++;
    exp_q.push_back('{0, SURSP_ERROR, 32'h0});
    for (int k = 0; k < 30 && obs_q.size() < 2; k++) cyc();
    total++;
    if (snooped !== '0)
      $display("FAIL badop_nosnoop: got %b required 0000", snooped);
    else passed++;
    hit_cfg[0] = 1'b1;
    dat_cfg[0] = 32'hAAAA;
    op_cfg[1]  = SDREQ_INV;
    want[1]++;
    exp_q.push_back('{1, SURSP_OKAY, 32'h0});
    for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL wb_badop: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL wb_badop: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
    total++;
    if (last_sop !== SUREQ_INV)
      $display("FAIL inv_sureq: got %0d required %0d", last_sop, SUREQ_INV);
    else passed++;
  endtask

  task automatic test_error_backpressure();
    txn_t e, o;
    clear_cfg();
    rsp_cfg[1] = SDRSP_ERROR;
    hit_cfg[2] = 1'b1;
    dat_cfg[2] = 32'h55;
    stall[3]   = 5;
    want[0]++;
    exp_q.push_back('{0, SURSP_ERROR, 32'h0});
    for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL err_bp: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL err_bp: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
    total++;
    if (stall_seen[3] !== 5)
      $display("FAIL err_bp_hold: got %0d required 5", stall_seen[3]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    txn_t e, o;
    clear_cfg();
    silent[3] = 1'b1;
    want[2]++;
    repeat (12) cyc();
    total++;
    if (obs_q.size() !== 0 || bif.sdrsp_ready[3] !== 1'b1)
      $display("FAIL mid_waiting: got %0d/%b required 0/1",
               obs_q.size(), bif.sdrsp_ready[3]);
    else passed++;
    rst_n = 1'b0;
    cyc();
    total++;
    if ({bif.sdreq_ready, bif.sureq_valid, bif.sdrsp_ready,
         bif.sursp_valid} !== '0)
      $display("FAIL mid_reset_handshake: got %0h required 0",
               {bif.sdreq_ready, bif.sureq_valid,
                bif.sdrsp_ready, bif.sursp_valid});
    else passed++;
    total++;
    if ({bif.sureq_op, bif.sureq_addr, bif.sursp_rsp,
         bif.sursp_data} !== '0)
      $display("FAIL mid_reset_fields: got %0h required 0",
               {bif.sureq_op, bif.sureq_addr,
                bif.sursp_rsp, bif.sursp_data});
    else passed++;
    rst_n = 1'b1;
    silent[3] = 1'b0;
    want[0]++;
    exp_q.push_back('{0, SURSP_FETCH, 32'h0});
    for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL mid_recover: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL mid_recover: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
  endtask

`ifdef SNOOP_TIMEOUT_EN
  task automatic test_timeout();
    txn_t e, o;
    clear_cfg();
    silent[0] = 1'b1;
    want[1]++;
    exp_q.push_back('{1, SURSP_ERROR, 32'h0});
    for (int k = 0; k < 400 && obs_q.size() < exp_q.size(); k++) cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0)
        $display("FAIL timeout: no response, required rsp %0d", e.rsp);
      else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.rsp !== e.rsp || o.data !== e.data)
          $display("FAIL timeout: got %0d/%0d/%h required %0d/%0d/%h",
                   o.idx, o.rsp, o.data, e.idx, e.rsp, e.data);
        else passed++;
      end
    end
  endtask
`endif

  initial begin
    bif.sdreq_valid = '0;
    bif.sdreq_op    = '0;
    bif.sdreq_addr  = '0;
    bif.sureq_ready = '1;
    bif.sdrsp_valid = '0;
    bif.sdrsp_rsp   = '0;
    bif.sdrsp_hit   = '0;
    bif.sdrsp_data  = '0;
    bif.sursp_ready = '1;
    for (int i = 0; i < N; i++) begin
      want[i] = 0;
      done[i] = 0;
    end
    ncyc = 0;
    cur_req = 0;
    acc_at = 0;
    rsp_at = 0;
    prev_rv = 1'b0;
    last_sop = '0;
    last_saddr = '0;
    clear_cfg();
    test_reset();
    test_read_nosharer();
    test_sharer();
    test_round_robin();
    test_wb_badop();
    test_error_backpressure();
    test_reset_mid();
`ifdef SNOOP_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
